// File: rtl/serial_frame_rx.sv
// Serial line deframer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Emits one-cycle done/parity_err/frame_err strobes and keeps saturating statistics.
module serial_frame_rx #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     good_count,
    output logic [CNT_W-1:0]     err_count
);

    localparam int              BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic            LAST_STOP = (STOP_BITS == 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        DONE      = 3'd4,
        BAD_PAR   = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic                   parity_bit;
    logic                   wait_first;
    logic                   parity_ok;

    always_comb begin
        parity_ok = 1'b1;
        if (PARITY_MODE == 1) begin
            parity_ok = ~(^shift_reg ^ parity_bit);
        end else if (PARITY_MODE == 2) begin
            parity_ok = ^shift_reg ^ parity_bit;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:      next_state = serial_in ? IDLE : DATA;
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    next_state = (PARITY_MODE != 0) ? PARITY : STOP;
                end else begin
                    next_state = DATA;
                end
            end
            PARITY:    next_state = STOP;
            STOP: begin
                if (!serial_in) begin
                    next_state = WAIT_IDLE;
                end else if (stop_cnt != LAST_STOP) begin
                    next_state = STOP;
                end else begin
                    next_state = parity_ok ? DONE : BAD_PAR;
                end
            end
            DONE,
            BAD_PAR:   next_state = serial_in ? IDLE : DATA;
            WAIT_IDLE: next_state = serial_in ? IDLE : WAIT_IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // frame_err is only the first WAIT_IDLE cycle, tracked by wait_first
    assign done       = (state == DONE);
    assign parity_err = (state == BAD_PAR);
    assign frame_err  = (state == WAIT_IDLE) && wait_first;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            wait_first <= 1'b0;
            data_out   <= '0;
            good_count <= '0;
            err_count  <= '0;
        end else begin
            state      <= next_state;
            wait_first <= (state != WAIT_IDLE);

            if (state == DATA) begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (bit_cnt == BW'(i)) begin
                        shift_reg[i] <= serial_in;
                    end
                end
                bit_cnt <= bit_cnt + BW'(1);
            end else begin
                bit_cnt <= '0;
            end

            if (state == PARITY) begin
                parity_bit <= serial_in;
            end

            if (state == STOP) begin
                stop_cnt <= ~stop_cnt;
            end else begin
                stop_cnt <= 1'b0;
            end

            if (state == STOP && next_state == DONE) begin
                data_out <= shift_reg;
            end

            if (state == DONE && good_count != CNT_MAX) begin
                good_count <= good_count + CNT_W'(1);
            end

            if ((state == BAD_PAR || (state == WAIT_IDLE && wait_first)) && err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Parametrised successor to the single-purpose serial input FSM. It receives one bit per clock from a serial line and deframes it: start bit, DATA_BITS data bits sent LSB-first, an optional parity bit, then STOP_BITS stop bits. It delivers each completed word with a one-cycle done strobe. It reports parity and framing errors and keeps saturating statistics counters. It sits between the line sampler and the word-level consumer logic.

Parameters:
DATA_BITS, 8, data bits per frame (legal range 1..16)
PARITY_MODE, 0, 0 = no parity bit, 1 = even parity, 2 = odd parity
STOP_BITS, 1, number of stop bits (1 or 2)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock; all logic is rising-edge
reset_n  in  1  synchronous reset, active-low
serial_in  in  1  serial line, sampled every clk; idle level is 1
data_out  out  DATA_BITS  last word received with good framing and good parity
done  out  1  one-cycle strobe; data_out is valid in this cycle
parity_err  out  1  one-cycle strobe: framing was good but parity was wrong
frame_err  out  1  one-cycle strobe: a stop bit was sampled as 0
busy  out  1  high whenever the state is not IDLE
good_count  out  CNT_W  number of done strobes since reset, saturating
err_count  out  CNT_W  number of parity_err plus frame_err strobes since reset, saturating

Behaviour:
- Reset: when reset_n is 0 at a rising edge, the state goes to IDLE. data_out, the shift register, the bit counter and both statistics counters clear to 0. done, parity_err, frame_err and busy are 0 in the cycle after reset. Reset mid-frame abandons the frame with no strobe.
- States: IDLE, DATA, PARITY, STOP, DONE, BAD_PAR, WAIT_IDLE.
- IDLE: if serial_in is 0 (start bit), go to DATA with the bit counter at 0. Otherwise stay in IDLE.
- DATA: shift serial_in into the shift register at bit index bit_cnt, so the first data bit becomes bit 0. Increment bit_cnt. After the sample at bit_cnt equal to DATA_BITS-1, go to PARITY if PARITY_MODE is not 0, otherwise go to STOP.
- PARITY: sample serial_in into the parity register, then go to STOP.
- Parity check:
  - Even mode is good when the XOR of the data bits and the parity bit is 0.
  - Odd mode is good when that XOR is 1.
  - Mode 0 is always good.
- STOP: the stop counter counts from 0 to STOP_BITS-1.
  - If serial_in is 0, go to WAIT_IDLE and pulse frame_err in the first WAIT_IDLE cycle.
  - If serial_in is 1 and this is not the last stop bit, stay in STOP.
  - If serial_in is 1 on the last stop bit, go to DONE when parity is good, or to BAD_PAR when parity is bad.
- DONE: done is 1 for this cycle only. data_out takes the shift register value on entry to DONE (registered), and holds it until the next DONE. If serial_in is 0, it is a back-to-back start bit: go to DATA with bit_cnt at 0. Otherwise go to IDLE.
- BAD_PAR: parity_err is 1 for this cycle only, and data_out is not updated. The exit rules are the same as DONE.
- WAIT_IDLE: frame_err is 1 on the first cycle only. Stay here while serial_in is 0. Go to IDLE on the first cycle that serial_in is 1.
- Latency: done rises exactly one cycle after the last stop bit is sampled.
- Outputs done, parity_err, frame_err and busy are Moore outputs, decoded from the state register only.
- Strobe exclusivity: at most one of done, parity_err and frame_err is high in any cycle.
- Counters: good_count increments on each done cycle. err_count increments on each parity_err or frame_err cycle. Both hold at 2^CNT_W-1 and never wrap.
- Width rules:
  - bit_cnt is $clog2(DATA_BITS+1) bits wide.
  - The stop counter is 1 bit wide.
  - No intermediate signal may truncate DATA_BITS=16.
- Illegal state encodings recover to IDLE on the next clock.

Test Plan:
- Default parameters, line at 1, then start bit 0, then data bits 1,0,1,0,0,1,0,1 (0xA5 sent LSB-first), then stop bit 1 -> done is high for exactly one cycle, 10 cycles after the start-bit cycle. data_out is 0xA5, good_count is 1, busy is low the cycle after.
- Two frames sent back-to-back, 0x3C then 0xC3, with the second start bit in the DONE cycle -> two done strobes 10 cycles apart. data_out reads 0x3C, then 0xC3. good_count is 2.
- Frame 0x55 sent with stop bit 0, then line held at 0 for 5 cycles, then 1 -> frame_err pulses once, done never rises, data_out keeps its previous value. Return to IDLE one cycle after the line goes high. err_count increments by 1.
- PARITY_MODE=1, DATA_BITS=7: frame 0x41 with parity bit 0 -> done, data_out is 0x41. The same frame with parity bit 1 -> parity_err, data_out unchanged.
- STOP_BITS=2, DATA_BITS=16: frame 0xBEEF with stop bits 1,1 -> done, data_out is 0xBEEF. Stop bits 1,0 -> frame_err.
- reset_n driven low for 1 cycle after 4 data bits of a frame -> no strobe. Outputs and counters read 0. A following clean frame of 0x12 is received correctly.
